fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage with an IF/ID pipeline register.
- Owns the PC, drives the instruction-memory address and latches the fetched word.
- Presents decoded instruction fields (opcode, funct, rs, rt, rd, shamt, imm16) to the downstream control unit and register file.
- Computes branch and jump targets from the IF/ID contents, and handles stall and flush for the 5-stage pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_ADDR_W, 10, word-address width of the instruction memory (1024 words).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  IMEM_ADDR_W  word address to instruction memory, equal to pc[IMEM_ADDR_W+1:2].
- imem_rdata  in  32  instruction word; combinational read, valid in the same cycle.
- stall  in  1  hazard unit request to hold PC and IF/ID.
- jump  in  1  Jump decode of the instruction currently in IF/ID.
- branch_taken  in  1  Branch AND zero for the instruction currently in IF/ID.
- pc  out  32  current fetch PC.
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- id_pc4  out  32  PC+4 of the instruction in IF/ID.
- id_instr  out  32  raw instruction in IF/ID.
- id_opcode  out  6  id_instr[31:26].
- id_funct  out  6  id_instr[5:0].
- id_rs  out  5  id_instr[25:21].
- id_rt  out  5  id_instr[20:16].
- id_rd  out  5  id_instr[15:11].
- id_shamt  out  5  id_instr[10:6].
- id_imm  out  16  id_instr[15:0].
- fetch_count  out  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset, when rst=1 at an edge, overrides all other inputs:
  - pc <= RESET_PC;
  - id_instr <= 0 (sll $0,$0,0 = NOP), id_pc4 <= 0, id_valid <= 0;
  - fetch_count <= 0.
- Reset mid-operation discards any pending redirect or stall. The first fetch after reset is RESET_PC.
- Targets are combinational from IF/ID:
  - branch_target = id_pc4 + (sign_extend(id_imm) << 2), in 32-bit modular arithmetic.
  - jump_target = {id_pc4[31:28], id_instr[25:0], 2'b00}.
- jump and branch_taken are honoured only when id_valid=1. When id_valid=0 they are ignored.
- Priority each cycle, with rst=0:
  1. jump (valid): pc <= jump_target; IF/ID <= bubble (instr 0, valid 0, pc4 0). The fetched word is discarded.
  2. branch_taken (valid): pc <= branch_target; IF/ID <= bubble. If jump and branch_taken are both set, jump wins.
  3. stall: pc, IF/ID and fetch_count hold. imem_addr stays stable, so the same word is re-read.
  4. Otherwise: pc <= pc + 4; id_instr <= imem_rdata; id_pc4 <= pc + 4; id_valid <= 1; fetch_count += 1.
- A redirect overrides a simultaneous stall. The redirecting instruction leaves ID, and the bubble is safe for the hazard unit.
- Latency:
  - An instruction at address A appears on the id_* outputs one cycle after pc=A, with no stall.
  - Taken branch or jump penalty is exactly one bubble cycle.
- Wrap-around:
  - pc+4 wraps modulo 2^32.
  - imem_addr truncates the upper PC bits, so the memory aliases.
  - fetch_count wraps modulo 2^32.
- pc[1:0] is always 00. Targets are word-aligned by construction.
- All id_* field outputs are pure slices of id_instr and carry no extra register delay.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h0000_0000;
  - field bit-position constants (OPCODE_MSB, RS_MSB, …);
  - opcode constants OP_J = 6'b000010 and OP_BEQ = 6'b000100, shared with the control unit.
- One sub-module is natural: next_pc_sel. It is combinational: inputs pc, id_pc4, id_instr, jump, branch_taken, id_valid, stall; outputs next_pc and flush.
- The PC register, IF/ID register and counter stay in fetch_stage.

Test Plan:
- Reset then run with imem[i] = 32'h2000_0000 | i, no stall → pc steps 0,4,8,12; id_instr is 32'h2000_0000 one cycle later, then 32'h2000_0001; fetch_count = 3 after 3 edges.
- Stall held 2 cycles with pc=8 → pc stays 8; id_instr and fetch_count unchanged; on release pc=12 and IF/ID advances normally.
- Instruction beq in IF/ID at id_pc4=0x14 with imm=16'hFFFC, branch_taken=1 → pc next = 0x04; IF/ID is a bubble (valid=0, instr 0) for one cycle; the fetch at 0x04 follows.
- Instruction j with index 26'h0000040 in IF/ID, id_pc4=0x1000_0008, stall=1 simultaneously → pc = 0x1000_0100; bubble inserted; stall ignored that cycle.
- jump=1 while id_valid=0 → ignored; pc advances by 4.
- rst asserted for one cycle mid-run with pc=0x40 → next pc=RESET_PC; id_valid=0; fetch_count=0; normal fetch resumes the following cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage and downstream decode/control logic.
// Holds the NOP encoding, instruction field bit positions, shared opcodes
// and the branch-offset helper.
package fetch_stage_pkg;

  // sll $0,$0,0 encodes as all zeros; used as the IF/ID bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Instruction field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;

  // Opcodes shared with the control unit
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  // Sign-extended word offset of a branch immediate, in bytes
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC select: picks jump / branch / hold / sequential PC and flags a flush.
// Latency: purely combinational. Backpressure: stall holds the PC unless a
// redirect from a valid IF/ID instruction overrides it.
// Ports: pc, id_pc4, id_instr, jump, branch_taken, id_valid, stall in;
//        next_pc, flush out.
module fetch_stage_next_pc_sel
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_instr,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic        id_valid,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic        flush
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        unused_opcode;

  assign branch_target = id_pc4 + branch_offset(id_instr[IMM_MSB:IMM_LSB]);
  assign jump_target   = {id_pc4[31:28], id_instr[JIDX_MSB:JIDX_LSB], 2'b00};

  // Opcode bits are decoded by the control unit, not here
  assign unused_opcode = ^id_instr[OPCODE_MSB:OPCODE_LSB];

  // Redirects come only from a real instruction in IF/ID and beat stall:
  // the redirecting instruction leaves ID, so its hazard no longer applies.
  always_comb begin
    next_pc = pc + 32'd4;
    flush   = 1'b0;
    if (id_valid && jump) begin
      next_pc = jump_target;
      flush   = 1'b1;
    end else if (id_valid && branch_taken) begin
      next_pc = branch_target;
      flush   = 1'b1;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: owns the PC, latches fetched words,
// exposes decoded fields. Latency: word at A appears on id_* one cycle after
// pc=A. Backpressure: stall holds PC/IF/ID/counter; redirects insert 1 bubble.
// Ports: clk, rst (sync, active-high); imem_addr/imem_rdata to instruction
// memory; stall, jump, branch_taken from hazard/control; pc, id_* fields and
// fetch_count out.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   stall,
  input  logic                   jump,
  input  logic                   branch_taken,
  output logic [31:0]            pc,
  output logic                   id_valid,
  output logic [31:0]            id_pc4,
  output logic [31:0]            id_instr,
  output logic [5:0]             id_opcode,
  output logic [5:0]             id_funct,
  output logic [4:0]             id_rs,
  output logic [4:0]             id_rt,
  output logic [4:0]             id_rd,
  output logic [4:0]             id_shamt,
  output logic [15:0]            id_imm,
  output logic [31:0]            fetch_count
);

  logic [31:0] next_pc;
  logic        flush;

  // Upper PC bits are dropped, so the memory aliases across the address space
  assign imem_addr = pc[IMEM_ADDR_W+1:2];

  fetch_stage_next_pc_sel u_next_pc_sel (
    .pc           (pc),
    .id_pc4       (id_pc4),
    .id_instr     (id_instr),
    .jump         (jump),
    .branch_taken (branch_taken),
    .id_valid     (id_valid),
    .stall        (stall),
    .next_pc      (next_pc),
    .flush        (flush)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_instr    <= NOP_INSTR;
      id_pc4      <= 32'd0;
      id_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (flush) begin
      // Fetched word is on the wrong path: drop it and insert a bubble
      pc       <= next_pc;
      id_instr <= NOP_INSTR;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      // Without redirect or stall, next_pc is pc+4
      pc          <= next_pc;
      id_instr    <= imem_rdata;
      id_pc4      <= next_pc;
      id_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
  assign id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];
  assign id_rs     = id_instr[RS_MSB:RS_LSB];
  assign id_rt     = id_instr[RT_MSB:RT_LSB];
  assign id_rd     = id_instr[RD_MSB:RD_LSB];
  assign id_shamt  = id_instr[SHAMT_MSB:SHAMT_LSB];
  assign id_imm    = id_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a scoreboarded main instance at RESET_PC=0 and a
// directed instance at RESET_PC=0x1000_0000 for the jump-over-stall case.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int AW = 10;
  localparam logic [31:0] J_WORD   = {OP_J, 26'h0000040};
  localparam logic [31:0] BEQ_WORD = {OP_BEQ, 5'd1, 5'd2, 16'hFFFC};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst = 1'b1, stall = 1'b0, jump = 1'b0, branch_taken = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata, pc, id_pc4, id_instr, fetch_count;
  logic          id_valid;
  logic [5:0]    id_opcode, id_funct;
  logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
  logic [15:0]   id_imm;

  // high-region instance
  logic          h_rst = 1'b1, h_stall = 1'b0, h_jump = 1'b0, h_branch_taken = 1'b0;
  logic [AW-1:0] h_imem_addr;
  logic [31:0]   h_imem_rdata, h_pc, h_id_pc4, h_id_instr, h_fetch_count;
  logic          h_id_valid;
  logic [5:0]    h_id_opcode, h_id_funct;
  logic [4:0]    h_id_rs, h_id_rt, h_id_rd, h_id_shamt;
  logic [15:0]   h_id_imm;

  logic [31:0] imem [0:(1<<AW)-1];
  assign imem_rdata   = imem[imem_addr];
  assign h_imem_rdata = (h_imem_addr == 10'd1) ? J_WORD : (32'h2000_0000 | {22'd0, h_imem_addr});

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .jump(jump), .branch_taken(branch_taken), .pc(pc),
    .id_valid(id_valid), .id_pc4(id_pc4), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_imm(id_imm), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'h1000_0000), .IMEM_ADDR_W(AW)) u_dut_hi (
    .clk(clk), .rst(h_rst), .imem_addr(h_imem_addr), .imem_rdata(h_imem_rdata),
    .stall(h_stall), .jump(h_jump), .branch_taken(h_branch_taken), .pc(h_pc),
    .id_valid(h_id_valid), .id_pc4(h_id_pc4), .id_instr(h_id_instr),
    .id_opcode(h_id_opcode), .id_funct(h_id_funct), .id_rs(h_id_rs), .id_rt(h_id_rt),
    .id_rd(h_id_rd), .id_shamt(h_id_shamt), .id_imm(h_id_imm), .fetch_count(h_fetch_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] cnt;
    logic        valid;
  } exp_t;

  exp_t m;          // reference state after the last driven edge
  exp_t sb[$];      // expected states awaiting the DUT edge
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One main-instance cycle: drive inputs, push the reference next state,
  // then compare every output against the popped expectation.
  task automatic step(input logic s, input logic j, input logic b, input logic r);
    exp_t e;
    exp_t got_e;
    logic [31:0] ins;
    @(negedge clk);
    stall = s; jump = j; branch_taken = b; rst = r;
    e = m;
    if (r) begin
      e.pc = 32'h0; e.pc4 = 32'h0; e.instr = 32'h0; e.valid = 1'b0; e.cnt = 32'h0;
    end else if (m.valid && j) begin
      e.pc = {m.pc4[31:28], m.instr[25:0], 2'b00};
      e.pc4 = 32'h0; e.instr = 32'h0; e.valid = 1'b0;
    end else if (m.valid && b) begin
      e.pc = m.pc4 + {{14{m.instr[15]}}, m.instr[15:0], 2'b00};
      e.pc4 = 32'h0; e.instr = 32'h0; e.valid = 1'b0;
    end else if (!s) begin
      e.instr = imem[m.pc[11:2]];
      e.pc    = m.pc + 32'd4;
      e.pc4   = m.pc + 32'd4;
      e.valid = 1'b1;
      e.cnt   = m.cnt + 32'd1;
    end
    sb.push_back(e);
    m = e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got_e = sb.pop_front();
      ins = got_e.instr;
      check("pc",          pc,                   got_e.pc);
      check("imem_addr",   {22'd0, imem_addr},   {22'd0, got_e.pc[11:2]});
      check("id_valid",    {31'd0, id_valid},    {31'd0, got_e.valid});
      check("id_pc4",      id_pc4,               got_e.pc4);
      check("id_instr",    id_instr,             ins);
      check("id_opcode",   {26'd0, id_opcode},   {26'd0, ins[31:26]});
      check("id_rs",       {27'd0, id_rs},       {27'd0, ins[25:21]});
      check("id_rt",       {27'd0, id_rt},       {27'd0, ins[20:16]});
      check("id_rd",       {27'd0, id_rd},       {27'd0, ins[15:11]});
      check("id_shamt",    {27'd0, id_shamt},    {27'd0, ins[10:6]});
      check("id_funct",    {26'd0, id_funct},    {26'd0, ins[5:0]});
      check("id_imm",      {16'd0, id_imm},      {16'd0, ins[15:0]});
      check("fetch_count", fetch_count,          got_e.cnt);
    end
  endtask

  task automatic hstep(input logic s, input logic j, input logic b, input logic r);
    @(negedge clk);
    h_stall = s; h_jump = j; h_branch_taken = b; h_rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    for (int i = 0; i < (1 << AW); i++) imem[i] = 32'h2000_0000 | i;
    imem[4] = BEQ_WORD;
    m = '{pc: 32'h0, pc4: 32'h0, instr: 32'h0, cnt: 32'h0, valid: 1'b0};

    // Reset, then sequential fetch
    step(0, 0, 0, 1);
    check("rst_pc", pc, 32'h0);
    step(0, 0, 0, 0);
    check("seq_pc4_instr", id_instr, 32'h2000_0000);
    step(0, 0, 0, 0);
    check("seq_pc8", pc, 32'h8);
    check("seq_instr1", id_instr, 32'h2000_0001);

    // Stall held two cycles at pc=8
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("stall_pc", pc, 32'h8);
    check("stall_cnt", fetch_count, 32'd2);
    step(0, 0, 0, 0);
    check("release_pc", pc, 32'hC);
    check("release_cnt", fetch_count, 32'd3);

    // Advance until beq (word 4) sits in IF/ID with id_pc4=0x14
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("beq_in_id", id_instr, BEQ_WORD);
    check("beq_pc4", id_pc4, 32'h14);
    step(0, 0, 1, 0);
    check("br_target", pc, 32'h4);
    check("br_bubble", {31'd0, id_valid}, 32'd0);

    // Redirects on a bubble are ignored
    step(0, 1, 1, 0);
    check("ign_pc", pc, 32'h8);
    check("ign_instr", id_instr, 32'h2000_0001);

    // Random stalls until pc=0x40
    guard = 0;
    while (m.pc != 32'h40 && guard < 100) begin
      step($urandom_range(0, 3) == 0, 0, 0, 0);
      guard++;
    end
    check("reach_pc40", pc, 32'h40);

    // Reset mid-run overrides stall and redirects
    step(1, 1, 1, 1);
    check("midrst_pc", pc, 32'h0);
    check("midrst_cnt", fetch_count, 32'd0);
    step(0, 0, 0, 0);
    check("postrst_pc", pc, 32'h4);
    check("postrst_valid", {31'd0, id_valid}, 32'd1);

    // High-region instance: jump beats branch and stall
    hstep(0, 0, 0, 1);
    check("h_rst_pc", h_pc, 32'h1000_0000);
    check("h_rst_cnt", h_fetch_count, 32'd0);
    hstep(0, 0, 0, 0);
    hstep(0, 0, 0, 0);
    check("h_j_in_id", h_id_instr, J_WORD);
    check("h_j_pc4", h_id_pc4, 32'h1000_0008);
    hstep(1, 1, 1, 0);
    check("h_jump_pc", h_pc, 32'h1000_0100);
    check("h_jump_valid", {31'd0, h_id_valid}, 32'd0);
    check("h_jump_instr", h_id_instr, 32'h0);
    check("h_jump_cnt", h_fetch_count, 32'd2);
    hstep(0, 0, 0, 0);
    check("h_after_pc", h_pc, 32'h1000_0104);
    check("h_after_instr", h_id_instr, 32'h2000_0040);
    check("h_after_pc4", h_id_pc4, 32'h1000_0104);
    check("h_after_cnt", h_fetch_count, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
